// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined WIDTH-bit add/subtract. The word is split into STAGES ripple
//   segments of SEG = WIDTH/STAGES bits; each stage sums one segment and
//   registers its carry for the next stage. One result per cycle, with
//   valid/ready handshakes on both sides and a single global advance.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   x/y/sub are valid this cycle
//   in_ready   block accepts an operand pair this cycle
//   x, y       operands (WIDTH bits)
//   sub        0: x+y, 1: x-y (two's complement)
//   out_valid  sum/carry/overflow hold a valid result
//   out_ready  consumer takes the result this cycle
//   sum        result bits (modulo 2^WIDTH)
//   carry      carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow of the selected operation
`timescale 1ns/1ps
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One ripple segment: {carry_out, SEG sum bits}.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  endfunction

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Stage registers. x_p/b_p form the skew pipeline for segments not yet
  // summed; sum_p accumulates finished low segments as the word moves on.
  logic             vld_p   [STAGES];
  logic [WIDTH-1:0] sum_p   [STAGES];
  logic             carry_p [STAGES];
  logic [WIDTH-1:0] x_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];

  // Per-stage inputs and next-state values.
  logic             v_in    [STAGES];
  logic [WIDTH-1:0] x_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];
  logic [SEG:0]     seg_res [STAGES];
  logic [WIDTH-1:0] s_nx    [STAGES];
  logic             c_nx    [STAGES];

  logic adv;

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    // Stage 0 takes the ports; subtraction is x + ~y + 1.
    v_in[0] = in_valid;
    x_in[0] = x;
    b_in[0] = sub ? ~y : y;
    c_in[0] = sub;
    s_in[0] = '0;
    // Stage k>0 takes the registered output of stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = vld_p[k-1];
      x_in[k] = x_p[k-1];
      b_in[k] = b_p[k-1];
      c_in[k] = carry_p[k-1];
      s_in[k] = sum_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_res[k]              = seg_add(x_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
      s_nx[k]                 = s_in[k];
      s_nx[k][k*SEG +: SEG]   = seg_res[k][SEG-1:0];
      c_nx[k]                 = seg_res[k][SEG];
    end
  end

  // ---- stage boundary: registers of stages 0..STAGES-1 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k]   <= 1'b0;
        sum_p[k]   <= '0;
        carry_p[k] <= 1'b0;
        x_p[k]     <= '0;
        b_p[k]     <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k]   <= v_in[k];
        sum_p[k]   <= s_nx[k];
        carry_p[k] <= c_nx[k];
        x_p[k]     <= x_in[k];
        b_p[k]     <= b_in[k];
      end
    end
  end

  assign out_valid = vld_p[LAST];
  assign sum       = sum_p[LAST];
  assign carry     = carry_p[LAST];
  assign overflow  = signed_ovf(x_p[LAST][WIDTH-1], b_p[LAST][WIDTH-1], sum_p[LAST][WIDTH-1]);

endmodule
